// File: rtl/matmul_sequencer_pkg.sv
// Shared encodings for the matrix sequencer: register-file transfer types,
// matrix selects and the sequencer FSM state encoding.
package matmul_sequencer_pkg;

    localparam logic [1:0] TYPE_CELL = 2'b00;
    localparam logic [1:0] TYPE_ROW  = 2'b01;
    localparam logic [1:0] TYPE_COL  = 2'b10;

    localparam logic [1:0] SEL_A = 2'b00;
    localparam logic [1:0] SEL_B = 2'b01;
    localparam logic [1:0] SEL_C = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_ROW = 3'd1,
        ST_RD_COL = 3'd2,
        ST_CALC   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/matmul_sequencer_dot_product_unit.sv
// Combinational dot product of two packed lane vectors, truncated to one cell.
module dot_product_unit #(
    parameter int size       = 4,
    parameter int cell_width = 32
) (
    input  logic [cell_width*size-1:0] in_a,
    input  logic [cell_width*size-1:0] in_b,
    output logic [cell_width-1:0]      out_sum
);

    logic [cell_width-1:0] w_prod [size];

    // Truncating each product first gives the same low bits as a full-width sum.
    generate
        for (genvar gi = 0; gi < size; gi++) begin : g_lane
            assign w_prod[gi] = in_a[gi*cell_width +: cell_width] * in_b[gi*cell_width +: cell_width];
        end
    endgenerate

    always_comb begin
        out_sum = '0;
        for (int n = 0; n < size; n++) begin
            out_sum = out_sum + w_prod[n];
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequences row/column reads from the matrix register file, forms each dot
// product and writes it back to C, one cell every four cycles.
module matmul_sequencer
    import matmul_sequencer_pkg::*;
#(
    parameter int size          = 4,
    parameter int address_width = 4,
    parameter int cell_width    = 32,
    parameter int width         = cell_width * size
) (
    input  logic                     in_clk,
    input  logic                     in_reset,
    input  logic                     in_start,
    input  logic [width-1:0]         in_rf_data,
    output logic [address_width-1:0] out_rf_address,
    output logic [width-1:0]         out_rf_data,
    output logic [1:0]               out_rf_type,
    output logic [1:0]               out_rf_select,
    output logic                     out_rf_read_en,
    output logic                     out_rf_write_en,
    output logic                     out_busy,
    output logic                     out_done
);

    localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

    state_t                   r_state;
    logic [IDX_W-1:0]         r_i;
    logic [IDX_W-1:0]         r_j;
    logic [width-1:0]         r_row;
    logic [cell_width-1:0]    r_result;
    logic [address_width-1:0] r_address;
    logic [1:0]               r_type;
    logic [1:0]               r_select;
    logic                     r_read_en;
    logic                     r_write_en;
    logic                     r_busy;
    logic                     r_done;

    logic [cell_width-1:0]    w_dot;
    logic [address_width-1:0] w_row_addr;
    logic [address_width-1:0] w_next_row_addr;
    logic [address_width-1:0] w_cell_addr;

    assign w_row_addr      = address_width'(r_i) * address_width'(size);
    assign w_next_row_addr = w_row_addr + address_width'(size);
    assign w_cell_addr     = w_row_addr + address_width'(r_j);

    dot_product_unit #(
        .size       (size),
        .cell_width (cell_width)
    ) u_dot (
        .in_a    (r_row),
        .in_b    (in_rf_data),
        .out_sum (w_dot)
    );

    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            r_state    <= ST_IDLE;
            r_i        <= '0;
            r_j        <= '0;
            r_row      <= '0;
            r_result   <= '0;
            r_address  <= '0;
            r_type     <= TYPE_CELL;
            r_select   <= SEL_A;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_start) begin
                        r_state   <= ST_RD_ROW;
                        r_i       <= '0;
                        r_j       <= '0;
                        r_busy    <= 1'b1;
                        r_read_en <= 1'b1;
                        r_type    <= TYPE_ROW;
                        r_select  <= SEL_A;
                        r_address <= '0;
                    end
                end
                ST_RD_ROW: begin
                    r_state   <= ST_RD_COL;
                    r_type    <= TYPE_COL;
                    r_select  <= SEL_B;
                    r_address <= address_width'(r_j);
                end
                ST_RD_COL: begin
                    r_row     <= in_rf_data;
                    r_state   <= ST_CALC;
                    r_read_en <= 1'b0;
                    r_type    <= TYPE_CELL;
                    r_select  <= SEL_A;
                    r_address <= '0;
                end
                ST_CALC: begin
                    r_result   <= w_dot;
                    r_state    <= ST_WRITE;
                    r_write_en <= 1'b1;
                    r_type     <= TYPE_CELL;
                    r_select   <= SEL_C;
                    r_address  <= w_cell_addr;
                end
                ST_WRITE: begin
                    r_write_en <= 1'b0;
                    if (r_j != LAST_IDX) begin
                        r_j       <= r_j + IDX_W'(1);
                        r_state   <= ST_RD_ROW;
                        r_read_en <= 1'b1;
                        r_type    <= TYPE_ROW;
                        r_select  <= SEL_A;
                        r_address <= w_row_addr;
                    end else if (r_i != LAST_IDX) begin
                        r_j       <= '0;
                        r_i       <= r_i + IDX_W'(1);
                        r_state   <= ST_RD_ROW;
                        r_read_en <= 1'b1;
                        r_type    <= TYPE_ROW;
                        r_select  <= SEL_A;
                        r_address <= w_next_row_addr;
                    end else begin
                        r_state   <= ST_DONE;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_type    <= TYPE_CELL;
                        r_select  <= SEL_A;
                        r_address <= '0;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_rf_address  = r_address;
    assign out_rf_data     = width'(r_result);
    assign out_rf_type     = r_type;
    assign out_rf_select   = r_select;
    assign out_rf_read_en  = r_read_en;
    assign out_rf_write_en = r_write_en;
    assign out_busy        = r_busy;
    assign out_done        = r_done;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a behavioural 4x4 register file.
module tb_matmul_sequencer;

    localparam int K  = 4;
    localparam int CW = 32;
    localparam int W  = CW * K;

    logic          in_clk;
    logic          in_reset;
    logic          in_start;
    logic [W-1:0]  in_rf_data;
    logic [3:0]    out_rf_address;
    logic [W-1:0]  out_rf_data;
    logic [1:0]    out_rf_type;
    logic [1:0]    out_rf_select;
    logic          out_rf_read_en;
    logic          out_rf_write_en;
    logic          out_busy;
    logic          out_done;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] mat_a [16];
    logic [31:0] mat_b [16];
    logic [31:0] mat_c [16];

    logic [3:0]   wr_addr_q [$];
    logic [1:0]   wr_type_q [$];
    logic [1:0]   wr_sel_q  [$];
    logic [W-1:0] wr_data_q [$];

    matmul_sequencer #(
        .size          (K),
        .address_width (4),
        .cell_width    (CW)
    ) dut (
        .in_clk          (in_clk),
        .in_reset        (in_reset),
        .in_start        (in_start),
        .in_rf_data      (in_rf_data),
        .out_rf_address  (out_rf_address),
        .out_rf_data     (out_rf_data),
        .out_rf_type     (out_rf_type),
        .out_rf_select   (out_rf_select),
        .out_rf_read_en  (out_rf_read_en),
        .out_rf_write_en (out_rf_write_en),
        .out_busy        (out_busy),
        .out_done        (out_done)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    // Register file: reads return data the cycle after they are issued.
    always @(posedge in_clk) begin : rf_model
        int r, c;
        r = int'(out_rf_address) / K;
        c = int'(out_rf_address) % K;
        if (out_rf_read_en) begin
            for (int n = 0; n < K; n++) begin
                if (out_rf_type == 2'b01 && out_rf_select == 2'b00)
                    in_rf_data[n*CW +: CW] <= mat_a[r*K + n];
                else if (out_rf_type == 2'b10 && out_rf_select == 2'b01)
                    in_rf_data[n*CW +: CW] <= mat_b[n*K + c];
                else
                    in_rf_data[n*CW +: CW] <= 32'hBAD0_BAD0;
            end
        end
        if (out_rf_write_en) begin
            wr_addr_q.push_back(out_rf_address);
            wr_type_q.push_back(out_rf_type);
            wr_sel_q.push_back(out_rf_select);
            wr_data_q.push_back(out_rf_data);
            if (out_rf_type == 2'b00 && out_rf_select == 2'b10)
                mat_c[out_rf_address] <= out_rf_data[31:0];
        end
    end

    // Protocol: RD_ROW -> RD_COL -> CALC (no enables) -> exactly one write.
    logic prev_row, prev_col, prev2_col;
    always @(negedge in_clk) begin
        if (!in_reset) begin
            prev_row  = 1'b0;
            prev_col  = 1'b0;
            prev2_col = 1'b0;
        end else begin
            if (out_rf_read_en || out_rf_write_en) begin
                tests_run++;
                if (out_rf_read_en && out_rf_write_en) begin
                    tests_failed++;
                    $display("FAIL proto_excl: read_en=%0b write_en=%0b required not both 1", out_rf_read_en, out_rf_write_en);
                end
            end
            if (prev_row) begin
                tests_run++;
                if (!(out_rf_read_en && out_rf_type == 2'b10)) begin
                    tests_failed++;
                    $display("FAIL proto_row_col: read_en=%0b type=%0d required column read", out_rf_read_en, out_rf_type);
                end
            end
            if (prev_col) begin
                tests_run++;
                if (out_rf_read_en || out_rf_write_en) begin
                    tests_failed++;
                    $display("FAIL proto_calc: read_en=%0b write_en=%0b required 0 0", out_rf_read_en, out_rf_write_en);
                end
            end
            if (prev2_col) begin
                tests_run++;
                if (!out_rf_write_en) begin
                    tests_failed++;
                    $display("FAIL proto_write: write_en=%0b required 1", out_rf_write_en);
                end
            end
            prev2_col = prev_col;
            prev_col  = out_rf_read_en && out_rf_type == 2'b10;
            prev_row  = out_rf_read_en && out_rf_type == 2'b01;
        end
    end

    task automatic clear_c();
        for (int n = 0; n < 16; n++) mat_c[n] = 32'hDEAD_BEEF;
        wr_addr_q.delete();
        wr_type_q.delete();
        wr_sel_q.delete();
        wr_data_q.delete();
    endtask

    // Starts one run and waits (bounded) for done; optional extra start pulse.
    task automatic do_run(input int pulse_at, output int busy_cycles, output int done_cycle);
        busy_cycles = 0;
        done_cycle  = 0;
        @(posedge in_clk); #1;
        in_start = 1'b1;
        @(posedge in_clk); #1;
        in_start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc > 1) begin
                @(posedge in_clk); #1;
            end
            in_start = 1'b0;
            if (out_busy) busy_cycles++;
            if (out_done) begin
                done_cycle = cyc;
                break;
            end
            if (cyc == pulse_at) in_start = 1'b1;
        end
        in_start = 1'b0;
    endtask

    task automatic check_timing(input string name, input int busy_cycles, input int done_cycle);
        tests_run++;
        if (busy_cycles !== 64) begin
            tests_failed++;
            $display("FAIL %s_busy: got %0d cycles, required 64", name, busy_cycles);
        end
        tests_run++;
        if (done_cycle !== 65) begin
            tests_failed++;
            $display("FAIL %s_done: got cycle %0d, required 65 (0 = timeout)", name, done_cycle);
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({out_busy, out_done, out_rf_read_en, out_rf_write_en} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b, required 0000", {out_busy, out_done, out_rf_read_en, out_rf_write_en});
        end
        tests_run++;
        if ({out_rf_address, out_rf_type, out_rf_select} !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_addr_type_sel: got %h, required 00", {out_rf_address, out_rf_type, out_rf_select});
        end
        tests_run++;
        if (out_rf_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_data: got %h, required 0", out_rf_data);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_identity();
        int bc, dc;
        for (int n = 0; n < 16; n++) begin
            mat_a[n] = (n / K == n % K) ? 32'd1 : 32'd0;
            mat_b[n] = 32'(n + 1);
        end
        clear_c();
        do_run(0, bc, dc);
        check_timing("identity", bc, dc);
        for (int n = 0; n < 16; n++) begin
            tests_run++;
            if (mat_c[n] !== 32'(n + 1)) begin
                tests_failed++;
                $display("FAIL identity_c%0d: got %h, required %h", n, mat_c[n], 32'(n + 1));
            end
        end
        $display("[TB] test_identity done busy=%0d done_cycle=%0d", bc, dc);
    endtask

    task automatic test_constant();
        int bc, dc;
        for (int n = 0; n < 16; n++) begin
            mat_a[n] = 32'd2;
            mat_b[n] = 32'd3;
        end
        clear_c();
        do_run(0, bc, dc);
        check_timing("constant", bc, dc);
        tests_run++;
        if (wr_addr_q.size() !== 16) begin
            tests_failed++;
            $display("FAIL constant_nwrites: got %0d, required 16", wr_addr_q.size());
        end
        for (int n = 0; n < 16 && n < wr_addr_q.size(); n++) begin
            tests_run++;
            if (wr_addr_q[n] !== 4'(n) || wr_type_q[n] !== 2'b00 || wr_sel_q[n] !== 2'b10
                || wr_data_q[n] !== W'(32'd24)) begin
                tests_failed++;
                $display("FAIL constant_write%0d: got addr=%0d type=%0d sel=%0d data=%h, required addr=%0d type=0 sel=2 data=%h",
                         n, wr_addr_q[n], wr_type_q[n], wr_sel_q[n], wr_data_q[n], n, W'(32'd24));
            end
        end
        $display("[TB] test_constant done writes=%0d", wr_addr_q.size());
    endtask

    task automatic test_wrap();
        int bc, dc;
        logic [31:0] ops [2];
        logic [31:0] exp_c [2];
        ops[0] = 32'h0001_0000; exp_c[0] = 32'h0000_0000;
        ops[1] = 32'hFFFF_FFFF; exp_c[1] = 32'h0000_0001;
        for (int t = 0; t < 2; t++) begin
            for (int n = 0; n < 16; n++) begin
                mat_a[n] = 32'd0;
                mat_b[n] = 32'd0;
            end
            mat_a[0] = ops[t];
            mat_b[0] = ops[t];
            clear_c();
            do_run(0, bc, dc);
            tests_run++;
            if (mat_c[0] !== exp_c[t] || mat_c[15] !== 32'd0) begin
                tests_failed++;
                $display("FAIL wrap%0d: got C0=%h C15=%h, required C0=%h C15=0", t, mat_c[0], mat_c[15], exp_c[t]);
            end
            $display("[TB] test_wrap op=%h C0=%h", ops[t], mat_c[0]);
        end
    endtask

    task automatic test_signed();
        int bc, dc;
        logic [31:0] exp_v;
        for (int n = 0; n < 16; n++) begin
            mat_a[n] = (n < K) ? 32'hFFFF_FFFF : 32'd0;
            mat_b[n] = 32'd2;
        end
        clear_c();
        do_run(0, bc, dc);
        for (int n = 0; n < 16; n++) begin
            exp_v = (n < K) ? 32'hFFFF_FFF8 : 32'd0;
            tests_run++;
            if (mat_c[n] !== exp_v) begin
                tests_failed++;
                $display("FAIL signed_c%0d: got %h, required %h", n, mat_c[n], exp_v);
            end
        end
        $display("[TB] test_signed done C0=%h", mat_c[0]);
    endtask

    task automatic test_start_ignored();
        int bc, dc;
        for (int n = 0; n < 16; n++) begin
            mat_a[n] = (n / K == n % K) ? 32'd1 : 32'd0;
            mat_b[n] = 32'(3 * n + 5);
        end
        clear_c();
        do_run(10, bc, dc);
        check_timing("restart", bc, dc);
        tests_run++;
        if (wr_addr_q.size() !== 16) begin
            tests_failed++;
            $display("FAIL restart_nwrites: got %0d, required 16", wr_addr_q.size());
        end
        for (int n = 0; n < 16; n++) begin
            tests_run++;
            if (mat_c[n] !== 32'(3 * n + 5)) begin
                tests_failed++;
                $display("FAIL restart_c%0d: got %h, required %h", n, mat_c[n], 32'(3 * n + 5));
            end
        end
        $display("[TB] test_start_ignored done busy=%0d", bc);
    endtask

    task automatic test_reset_mid();
        int bc, dc;
        @(posedge in_clk); #1;
        in_start = 1'b1;
        @(posedge in_clk); #1;
        in_start = 1'b0;
        repeat (19) @(posedge in_clk);
        #1;
        tests_run++;
        if (!out_busy) begin
            tests_failed++;
            $display("FAIL midreset_pre_busy: got %0b, required 1", out_busy);
        end
        in_reset = 1'b0;
        #1;
        tests_run++;
        if ({out_busy, out_done, out_rf_read_en, out_rf_write_en, out_rf_address, out_rf_type, out_rf_select} !== 12'h000
            || out_rf_data !== '0) begin
            tests_failed++;
            $display("FAIL midreset_outputs: got flags/addr/type/sel=%h data=%h, required all 0",
                     {out_busy, out_done, out_rf_read_en, out_rf_write_en, out_rf_address, out_rf_type, out_rf_select}, out_rf_data);
        end
        repeat (2) @(posedge in_clk);
        #3;
        in_reset = 1'b1;
        @(posedge in_clk); #1;
        tests_run++;
        if (out_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_idle: busy=%0b, required 0", out_busy);
        end
        for (int n = 0; n < 16; n++) begin
            mat_a[n] = (n / K == n % K) ? 32'd1 : 32'd0;
            mat_b[n] = 32'(5 * n + 7);
        end
        clear_c();
        do_run(0, bc, dc);
        check_timing("midreset_rerun", bc, dc);
        for (int n = 0; n < 16; n++) begin
            tests_run++;
            if (mat_c[n] !== 32'(5 * n + 7)) begin
                tests_failed++;
                $display("FAIL midreset_c%0d: got %h, required %h", n, mat_c[n], 32'(5 * n + 7));
            end
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        in_reset   = 1'b0;
        in_start   = 1'b0;
        for (int n = 0; n < 16; n++) begin
            mat_a[n] = 32'd0;
            mat_b[n] = 32'd0;
            mat_c[n] = 32'd0;
        end
        repeat (3) @(posedge in_clk);
        #1;
        test_reset();
        #3;
        in_reset = 1'b1;
        test_identity();
        test_constant();
        test_wrap();
        test_signed();
        test_start_ignored();
        test_reset_mid();
        repeat (3) @(posedge in_clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Compute engine directly downstream of the matrix register file. On a start pulse it reads row i of A and column j of B from the register file. It forms their dot product and writes the cell back to C[i][j], covering all size*size cells. It is the sole master of the register-file port while busy; the host drives the register file only while the sequencer is idle.

Parameters:
size, 4, matrix dimension k (k x k matrices, k cells per row/column transfer)
address_width, 4, register-file address width; requires size*size <= 2**address_width
cell_width, 32, bits per matrix element
width, cell_width*size, bits of one row/column transfer

Ports:
in_clk  input  1  clock, rising edge
in_reset  input  1  asynchronous active-low reset
in_start  input  1  start request, sampled in IDLE only
in_rf_data  input  width  register-file out_data; valid the cycle after a read is issued
out_rf_address  output  address_width  register-file in_address
out_rf_data  output  width  register-file in_data
out_rf_type  output  2  cell=00, row=01, col=10
out_rf_select  output  2  A=00, B=01, C=10
out_rf_read_en  output  1  register-file read enable
out_rf_write_en  output  1  register-file write enable
out_busy  output  1  high from the cycle after start is accepted until the last write
out_done  output  1  one-cycle pulse after the final C write

Behaviour:
- Clock and reset: single clock in_clk. in_reset is asynchronous and active-low.
- Reset values: state IDLE, i=j=0, all outputs 0, row_reg and result 0.
- All outputs are registered.
- In IDLE the read enable, write enable and busy outputs are 0.
- FSM states: IDLE, RD_ROW, RD_COL, CALC, WRITE, DONE.
  - IDLE: if in_start=1, go to RD_ROW with i=j=0; otherwise stay.
  - RD_ROW: read_en=1, type=01, select=00, address=i*size. Next: RD_COL.
  - RD_COL: read_en=1, type=10, select=01, address=j. Capture row_reg <= in_rf_data. Next: CALC.
  - CALC: read_en=0. Register result <= dot(row_reg, in_rf_data). Next: WRITE.
  - WRITE: write_en=1, type=00, select=10, address=i*size+j. out_rf_data = result in the low cell, upper cells 0.
    - If j<size-1: j++, go to RD_ROW.
    - Else if i<size-1: j=0, i++, go to RD_ROW.
    - Else: go to DONE.
  - DONE: out_done=1 for one cycle, busy=0. Next: IDLE.
- Timing: 4 cycles per element. out_busy is high for exactly 4*size*size cycles (64 at size=4). out_done asserts on the next cycle.
- Arithmetic: sum over lanes of row[n]*col[n], truncated to the low cell_width bits (modulo 2**cell_width). This result is identical for two's-complement signed and unsigned operands. No saturation and no overflow flag.
- Lane n of a transfer occupies bits [n*cell_width +: cell_width].
- read_en and write_en are never both high in the same cycle. Outside RD_ROW, RD_COL and WRITE, type and select hold 00 and address holds 0.
- in_rf_data is only sampled in RD_COL and CALC. High-Z values at other times are ignored.
- in_start while busy or in DONE is ignored. No queuing.
- Reset mid-operation returns the FSM to IDLE immediately and clears all outputs. C writes already completed stay in the register file, subject to that file's own reset.
- There is no abort input.

Decomposition:
- Shared package: register-file type encodings (TYPE_CELL=2'b00, TYPE_ROW=2'b01, TYPE_COL=2'b10), matrix selects (SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10), FSM state encoding.
- Sub-module dot_product_unit (parameters size and cell_width): purely combinational, two width-bit vectors in, cell_width-bit truncated sum out. The sequencer registers its output in CALC.

Test Plan:
- Identity test, size=4:
  - Stimulus: A=I, B[n]=n+1 for cells 0..15, pulse start.
  - Expect: C equals B; out_busy high for 64 cycles; out_done on cycle 65 after start acceptance.
- Constant matrices: A all 2, B all 3 -> all 16 C cells = 24. Write addresses appear in order 0,1,...,15 with type=00 and select=10.
- Wrap-around: A[0][0]=B[0][0]=32'h0001_0000, all other cells 0 -> C[0]=0. Also A[0][0]=B[0][0]=32'hFFFF_FFFF -> C[0]=1.
- Signed operands: row 0 of A all 32'hFFFF_FFFF (-1), B all 2 -> C[0..3]=32'hFFFF_FFF8 (-8); other C cells 0.
- Start and reset during operation:
  - Pulse start again at cycle 10: ignored; the write sequence and total time are unchanged.
  - Separate run: assert in_reset low at cycle 20 -> outputs 0 within the same cycle, state IDLE. A new start then completes a full, correct run.
- Protocol checker (all tests): read_en and write_en never both 1. Each RD_ROW/RD_COL pair is followed by CALC with read_en=0, then exactly one write.
